// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes
// sampled with en, and the burst controller state encoding.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHL   = 3'b001;  // shift left, sin enters at bit 0
  localparam logic [2:0] MODE_SHR   = 3'b010;  // shift right, sin enters at MSB
  localparam logic [2:0] MODE_ROL   = 3'b011;
  localparam logic [2:0] MODE_ROR   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;  // also aborts a running burst
  localparam logic [2:0] MODE_RSVD  = 3'b111;  // behaves as hold

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/burst_ctrl.sv
// Burst controller: counts a programmed number of serial shifts, raising
// shift_en once per edge while running and pulsing done on completion.
module burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             shift_en
);

  // Longest meaningful burst; larger requests saturate here.
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // State, counter and done-pulse registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: accept a burst in IDLE, count shifts down in RUN.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            // Empty burst completes immediately without entering RUN.
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = (len > MAX_CNT) ? MAX_CNT : len;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (r_state == ST_RUN);
  assign shift_en = (r_state == ST_RUN) && !abort;
  assign done     = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal storage register: per-cycle hold/shift/rotate/load/clear on en,
// plus a self-timed serial burst driven by burst_ctrl.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int  WIDTH     = 8,
  parameter int  LSB_FIRST = 1,
  localparam int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qc,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_burst_q;
  logic             w_shift_en;
  logic             w_busy;
  logic             w_abort;

  // A clear request is the only en operation honoured during a burst.
  assign w_abort = en && (mode == MODE_CLEAR);

  burst_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_burst_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (w_abort),
    .len      (len),
    .busy     (w_busy),
    .done     (done),
    .shift_en (w_shift_en)
  );

  // One burst step in the configured direction, sin filling the vacated bit.
  assign w_burst_q = (LSB_FIRST != 0) ? {sin, r_q[WIDTH-1:1]}
                                      : {r_q[WIDTH-2:0], sin};

  // Next-word selection: burst shift, abort clear, or the strobed mode op.
  always_comb begin
    w_q_nxt = r_q;
    if (w_shift_en) begin
      w_q_nxt = w_burst_q;
    end else if (w_busy) begin
      if (w_abort) w_q_nxt = '0;
    end else if (en && !start) begin
      case (mode)
        MODE_SHL:   w_q_nxt = {r_q[WIDTH-2:0], sin};
        MODE_SHR:   w_q_nxt = {sin, r_q[WIDTH-1:1]};
        MODE_ROL:   w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        MODE_ROR:   w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
        MODE_LOAD:  w_q_nxt = d;
        MODE_CLEAR: w_q_nxt = '0;
        MODE_HOLD,
        MODE_RSVD:  w_q_nxt = r_q;
        default:    w_q_nxt = r_q;
      endcase
    end
  end

  // Storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= w_q_nxt;
  end

  assign q    = r_q;
  assign qc   = ~r_q;
  assign sout = (LSB_FIRST != 0) ? r_q[0] : r_q[WIDTH-1];
  assign busy = w_busy;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, LSB_FIRST=1). Expected outputs
// are queued when stimulus is driven and popped after the following edge.
module tb_univ_shift_reg;
  import shift_reg_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qc;
  logic             sout;
  logic             busy;
  logic             done;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic [7:0] m;

  univ_shift_reg #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .start (start),
    .len   (len),
    .q     (q),
    .qc    (qc),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic expect_out(input string tag, input logic [7:0] eq,
                            input logic eb, input logic ed);
    sb.push_back('{tag, eq, eb, ed});
  endtask

  // Pop one expectation and compare q, qc, sout, busy, done together.
  task automatic check();
    exp_t        e;
    logic [18:0] obs;
    logic [18:0] want;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed no expectation, expected one queued");
      return;
    end
    e    = sb.pop_front();
    obs  = {q, qc, sout, busy, done};
    want = {e.q, ~e.q, e.q[0], e.busy, e.done};
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed q=%h qc=%h sout=%b busy=%b done=%b, expected q=%h qc=%h sout=%b busy=%b done=%b",
             e.tag, q, qc, sout, busy, done, e.q, ~e.q, e.q[0], e.busy, e.done);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic do_op(input string tag, input logic [2:0] mc,
                       input logic [7:0] dv, input logic s, input logic [7:0] eq);
    en   = 1'b1;
    mode = mc;
    d    = dv;
    sin  = s;
    expect_out(tag, eq, 1'b0, 1'b0);
    tick();
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD; d = '0; sin = 1'b0;
    start = 1'b0; len = '0;
    #2;
    expect_out("reset", 8'h00, 1'b0, 1'b0);
    check();
    #1 rst_n = 1'b1;

    // Single operations.
    do_op("load_a5", MODE_LOAD, 8'hA5, 1'b0, 8'hA5);
    do_op("ror_a5",  MODE_ROR,  8'h00, 1'b0, 8'hD2);
    do_op("reload",  MODE_LOAD, 8'hA5, 1'b0, 8'hA5);
    do_op("rol_1",   MODE_ROL,  8'h00, 1'b1, 8'h4B);
    do_op("rol_2",   MODE_ROL,  8'h00, 1'b1, 8'h96);
    do_op("hold",    MODE_HOLD, 8'hFF, 1'b1, 8'h96);
    do_op("rsvd",    MODE_RSVD, 8'hFF, 1'b1, 8'h96);
    do_op("load_81", MODE_LOAD, 8'h81, 1'b0, 8'h81);
    do_op("shl_s1",  MODE_SHL,  8'h00, 1'b1, 8'h03);
    do_op("shr_s0",  MODE_SHR,  8'h00, 1'b0, 8'h01);
    do_op("clear",   MODE_CLEAR,8'hFF, 1'b1, 8'h00);
    // en low: mode is not applied.
    mode = MODE_LOAD; d = 8'h77;
    expect_out("en_low", 8'h00, 1'b0, 1'b0);
    tick();

    // Burst len=8 from C3; en with clear alongside start must be ignored.
    do_op("load_c3", MODE_LOAD, 8'hC3, 1'b0, 8'hC3);
    m = 8'hC3; sin = 1'b0; start = 1'b1; len = 4'd8; en = 1'b1; mode = MODE_CLEAR;
    expect_out("b8_start", m, 1'b1, 1'b0);
    tick();
    start = 1'b0; en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      // start during RUN must not restart or shorten the burst.
      if (k == 3) begin start = 1'b1; len = 4'd1; end
      else start = 1'b0;
      m = {sin, m[7:1]};
      expect_out($sformatf("b8_shift%0d", k), m, (k < 8), (k == 8));
      tick();
    end
    // Back-to-back: start in the done cycle, len=2, sin=1.
    start = 1'b1; len = 4'd2; sin = 1'b1;
    expect_out("b2_start", 8'h00, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    expect_out("b2_shift1", 8'h80, 1'b1, 1'b0);
    tick();
    expect_out("b2_shift2", 8'hC0, 1'b0, 1'b1);
    tick();
    expect_out("b2_done_clr", 8'hC0, 1'b0, 1'b0);
    tick();

    // len=0: done next cycle, busy never high, q unchanged.
    start = 1'b1; len = 4'd0;
    expect_out("len0_done", 8'hC0, 1'b0, 1'b1);
    tick();
    start = 1'b0;
    expect_out("len0_after", 8'hC0, 1'b0, 1'b0);
    tick();

    // len=15 saturates to 8 shifts; sin alternates so a 9th shift would show.
    do_op("load_3c", MODE_LOAD, 8'h3C, 1'b0, 8'h3C);
    m = 8'h3C; start = 1'b1; len = 4'd15;
    expect_out("b15_start", m, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      sin = k[0];
      m = {sin, m[7:1]};
      expect_out($sformatf("b15_shift%0d", k), m, (k < 8), (k == 8));
      tick();
    end
    sin = 1'b1;
    expect_out("b15_no_extra", m, 1'b0, 1'b0);
    tick();

    // Abort with clear at the 3rd shift cycle.
    do_op("load_c3b", MODE_LOAD, 8'hC3, 1'b0, 8'hC3);
    m = 8'hC3; sin = 1'b1; start = 1'b1; len = 4'd8;
    expect_out("ab_start", m, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      m = {sin, m[7:1]};
      expect_out($sformatf("ab_shift%0d", k), m, 1'b1, 1'b0);
      tick();
    end
    en = 1'b1; mode = MODE_CLEAR;
    expect_out("ab_clear", 8'h00, 1'b0, 1'b0);
    tick();
    en = 1'b0;
    expect_out("ab_no_done", 8'h00, 1'b0, 1'b0);
    tick();

    // Asynchronous reset mid-burst.
    do_op("load_5a", MODE_LOAD, 8'h5A, 1'b0, 8'h5A);
    m = 8'h5A; sin = 1'b0; start = 1'b1; len = 4'd8;
    expect_out("rb_start", m, 1'b1, 1'b0);
    tick();
    start = 1'b0;
    m = {sin, m[7:1]};
    expect_out("rb_shift1", m, 1'b1, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    expect_out("rb_async", 8'h00, 1'b0, 1'b0);
    check();
    #2 rst_n = 1'b1;
    expect_out("rb_no_done", 8'h00, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
